// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU datapath types and defaults
package fpu_pkg;

  localparam int DEF_WIDTH = 32;

  // Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration of the divider
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r_next,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_d_neg;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_r[WIDTH-1:0], i_q_msb};

  // Subtract by adding the two's complement of the zero-extended divisor.
  assign w_d_neg = ~{1'b0, i_d};
  assign w_diff  = w_shift + w_d_neg + (WIDTH+1)'(1);

  assign o_q_bit  = ~w_diff[WIDTH];
  assign o_r_next = o_q_bit ? w_diff : w_shift;

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential unsigned radix-2 restoring divider, fixed WIDTH-cycle latency
module divider
  import fpu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             res_ok,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_last;
  logic             w_zero_div;
  logic [WIDTH:0]   w_r_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_r      (r_r),
    .i_q_msb  (r_q[WIDTH-1]),
    .i_d      (r_d),
    .o_r_next (w_r_next),
    .o_q_bit  (w_q_bit)
  );

  assign w_q_next   = {r_q[WIDTH-2:0], w_q_bit};
  assign w_zero_div = (opB == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_STEP) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result registers move only on entry to DONE so they stay stable during RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_quot     <= '1;
        r_rem      <= opA;
        r_div_zero <= 1'b1;
      end else begin
        r_q   <= opA;
        r_r   <= '0;
        r_d   <= opB;
        r_cnt <= '0;
      end
    end else if (r_state == ST_RUN) begin
      r_r   <= w_r_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_quot     <= w_q_next;
        r_rem      <= w_r_next[WIDTH-1:0];
        r_div_zero <= 1'b0;
      end
    end
  end

  assign quot     = r_quot;
  assign rem      = r_rem;
  assign div_zero = r_div_zero;
  assign busy     = (r_state == ST_RUN);
  assign res_ok   = (r_state == ST_DONE);

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
module tb_divider;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         res_ok;
  logic         div_zero;

  int n_checks;
  int n_errors;

  divider #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .quot     (quot),
    .rem      (rem),
    .busy     (busy),
    .res_ok   (res_ok),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is raised here so a DONE state restarts back-to-back.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hold_q, input logic [31:0] exp_q,
                        input logic [31:0] exp_r);
    start = 1'b1;
    opA   = a;
    opB   = b;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    chk({tag, "_resok_off"}, 32'(res_ok), 32'd0);
    chk({tag, "_quot_hold"}, quot, hold_q);
    repeat (W - 1) @(negedge clk);
    chk({tag, "_not_early"}, 32'(res_ok), 32'd0);
    @(negedge clk);
    chk({tag, "_resok"}, 32'(res_ok), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_divz"}, 32'(div_zero), 32'd0);
    chk({tag, "_quot"}, quot, exp_q);
    chk({tag, "_rem"}, rem, exp_r);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    start    = 1'b0;
    opA      = '0;
    opB      = '0;
    repeat (2) @(negedge clk);
    chk("rst_quot", quot, 32'd0);
    chk("rst_rem", rem, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resok", 32'(res_ok), 32'd0);
    chk("rst_divz", 32'(div_zero), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op("big", 32'd4267680629, 32'd54491, 32'd0, 32'd78319, 32'd0);
    run_op("d100_7", 32'd100, 32'd7, 32'd78319, 32'd14, 32'd2);
    run_op("b2b_5_9", 32'd5, 32'd9, 32'd14, 32'd0, 32'd5);
    run_op("max_1", 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0);
    run_op("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0);

    start = 1'b1;
    opA   = 32'd1234;
    opB   = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("dz_resok", 32'(res_ok), 32'd1);
    chk("dz_divz", 32'(div_zero), 32'd1);
    chk("dz_quot", quot, 32'hFFFFFFFF);
    chk("dz_rem", rem, 32'd1234);
    chk("dz_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("dz_busy_hold", 32'(busy), 32'd0);
    chk("dz_resok_hold", 32'(res_ok), 32'd1);

    start = 1'b1;
    opA   = 32'd100;
    opB   = 32'd7;
    @(negedge clk);
    chk("chg_busy", 32'(busy), 32'd1);
    opA = 32'd9;
    opB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    opA   = 32'h12345678;
    opB   = 32'd0;
    @(negedge clk);
    chk("chg_quot_hold", quot, 32'hFFFFFFFF);
    repeat (W - 3) @(negedge clk);
    chk("chg_not_early", 32'(res_ok), 32'd0);
    @(negedge clk);
    chk("chg_resok", 32'(res_ok), 32'd1);
    chk("chg_quot", quot, 32'd14);
    chk("chg_rem", rem, 32'd2);
    chk("chg_divz", 32'(div_zero), 32'd0);

    start = 1'b1;
    opA   = 32'd1000;
    opB   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_quot", quot, 32'd0);
    chk("abort_rem", rem, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_resok", 32'(res_ok), 32'd0);
    chk("abort_divz", 32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_resok", 32'(res_ok), 32'd0);
    run_op("post_rst", 32'd4267680636, 32'd54491, 32'd0, 32'd78319, 32'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
